// File: rtl/dec_scanner_pkg.sv
// ============================================================================
// Module      : dec_scanner_pkg
// Description : Mode encodings and FSM state type shared by the dec_scanner
//               block and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_scanner_pkg;

   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_UP     = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;
   localparam logic [1:0] MODE_SHOT   = 2'b11;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dec_scanner_if.sv
// ============================================================================
// Module      : dec_scanner_if
// Description : Control and channel-select bundle of the dec_scanner block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dec_scanner_if #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
);

   logic                  en;
   logic [1:0]            mode;
   logic [SEL_W-1:0]      in;
   logic                  load;
   logic [DWELL_W-1:0]    dwell;
   logic [(1<<SEL_W)-1:0] out;
   logic [SEL_W-1:0]      idx;
   logic                  wrap;
   logic                  busy;

   modport master (
      output en, mode, in, load, dwell,
      input  out, idx, wrap, busy
   );

   modport slave (
      input  en, mode, in, load, dwell,
      output out, idx, wrap, busy
   );

endinterface

`default_nettype wire

// File: rtl/dec_onehot.sv
// ============================================================================
// Module      : dec_onehot
// Description : Combinational SEL_W-to-2**SEL_W one-hot decoder with enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_onehot #(
   parameter int SEL_W = 3
) (
   input  wire logic [SEL_W-1:0]      i_sel,
   input  wire logic                  i_en,
   output logic      [(1<<SEL_W)-1:0] o_onehot
);

   for (genvar g = 0; g < (1 << SEL_W); g++) begin : g_bit
      assign o_onehot[g] = i_en && (i_sel == SEL_W'(g));
   end

endmodule

`default_nettype wire

// File: rtl/dec_scanner.sv
// ============================================================================
// Module      : dec_scanner
// Description : Registered one-hot channel scanner: direct select, scan up,
//               scan down and single-shot sequencing with per-channel dwell.
//               Define DEC_SCANNER_BLANK_EN to insert a blank cycle per step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_scanner
   import dec_scanner_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  wire logic  clk,
   input  wire logic  rst,
   dec_scanner_if.slave bus
);

   localparam int OUT_W = 1 << SEL_W;
   localparam logic [SEL_W-1:0] c_idx_max = {SEL_W{1'b1}};

`ifdef DEC_SCANNER_BLANK_EN
   localparam bit c_blank_en = 1'b1;
`else
   localparam bit c_blank_en = 1'b0;
`endif

   logic [SEL_W-1:0]   idx_q,   idx_d;
   logic [DWELL_W-1:0] cnt_q,   cnt_d;
   logic [OUT_W-1:0]   out_q,   out_d;
   logic               wrap_q,  wrap_d;
   logic               busy_q,  busy_d;
   logic               blank_q, blank_d;
   logic [1:0]         mode_q,  mode_d;
   state_t             state_q, state_d;

   logic               w_show;
   logic               w_mode_chg;
   logic               w_dwell_done;
   logic               w_down;
   logic [SEL_W-1:0]   w_step_idx;
   logic               w_step_wrap;
   logic [OUT_W-1:0]   w_onehot;

   // >= rather than == so a live reduction of dwell below cnt steps at once
   assign w_dwell_done = (cnt_q >= bus.dwell);
   assign w_mode_chg   = (bus.mode != mode_q);
   assign w_down       = (bus.mode == MODE_DOWN);
   assign w_step_idx   = w_down ? (idx_q - SEL_W'(1)) : (idx_q + SEL_W'(1));
   assign w_step_wrap  = w_down ? (idx_q == '0) : (idx_q == c_idx_max);

   always_comb begin
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      blank_d = blank_q;
      mode_d  = mode_q;
      state_d = state_q;
      wrap_d  = 1'b0;
      w_show  = 1'b0;

      if (bus.en) begin
         mode_d = bus.mode;
         case (bus.mode)
            MODE_DIRECT: begin
               idx_d   = bus.in;
               cnt_d   = '0;
               busy_d  = 1'b0;
               blank_d = 1'b0;
               state_d = ST_IDLE;
               w_show  = 1'b1;
            end
            MODE_UP, MODE_DOWN: begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
               if (bus.load) begin
                  idx_d   = bus.in;
                  cnt_d   = '0;
                  blank_d = 1'b0;
                  w_show  = 1'b1;
               end else if (w_mode_chg) begin
                  cnt_d   = '0;
                  blank_d = 1'b0;
                  w_show  = 1'b1;
               end else if (blank_q) begin
                  blank_d = 1'b0;
                  w_show  = 1'b1;
               end else if (w_dwell_done) begin
                  idx_d   = w_step_idx;
                  cnt_d   = '0;
                  wrap_d  = w_step_wrap;
                  blank_d = c_blank_en;
                  w_show  = !c_blank_en;
               end else begin
                  cnt_d   = cnt_q + DWELL_W'(1);
                  w_show  = 1'b1;
               end
            end
            default: begin
               if (bus.load) begin
                  state_d = ST_RUN;
                  busy_d  = 1'b1;
                  idx_d   = '0;
                  cnt_d   = '0;
                  blank_d = 1'b0;
                  w_show  = 1'b1;
               end else if (w_mode_chg) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
                  blank_d = 1'b0;
               end else if (state_q == ST_RUN) begin
                  if (blank_q) begin
                     blank_d = 1'b0;
                     w_show  = 1'b1;
                  end else if (w_dwell_done && (idx_q == c_idx_max)) begin
                     // sequence complete: blank, park at channel 0
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                     idx_d   = '0;
                     cnt_d   = '0;
                     wrap_d  = 1'b1;
                  end else if (w_dwell_done) begin
                     idx_d   = idx_q + SEL_W'(1);
                     cnt_d   = '0;
                     blank_d = c_blank_en;
                     w_show  = !c_blank_en;
                  end else begin
                     cnt_d   = cnt_q + DWELL_W'(1);
                     w_show  = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   dec_onehot #(
      .SEL_W (SEL_W)
   ) u_onehot (
      .i_sel    (idx_d),
      .i_en     (w_show),
      .o_onehot (w_onehot)
   );

   assign out_d = w_onehot;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
         blank_q <= 1'b0;
         mode_q  <= MODE_DIRECT;
         state_q <= ST_IDLE;
      end else begin
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         wrap_q  <= wrap_d;
         busy_q  <= busy_d;
         blank_q <= blank_d;
         mode_q  <= mode_d;
         state_q <= state_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.idx  = idx_q;
   assign bus.wrap = wrap_q;
   assign bus.busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dec_scanner.sv
// ============================================================================
// Module      : tb_dec_scanner
// Description : Scoreboard testbench for dec_scanner with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_scanner;
   import dec_scanner_pkg::*;

   typedef struct {
      logic [7:0] out;
      logic [2:0] idx;
      logic       wrap;
      logic       busy;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   dec_scanner_if #(.SEL_W(3), .DWELL_W(8)) bus ();

   dec_scanner #(
      .SEL_W   (3),
      .DWELL_W (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                      input logic [2:0] i, input logic l, input logic [7:0] d,
                      input logic [7:0] eo, input logic [2:0] ei,
                      input logic ew, input logic eb, input string nm);
      exp_t x;
      @(negedge clk);
      rst       = r;
      bus.en    = e;
      bus.mode  = m;
      bus.in    = i;
      bus.load  = l;
      bus.dwell = d;
      x.out = eo; x.idx = ei; x.wrap = ew; x.busy = eb; x.name = nm;
      q.push_back(x);
   endtask

   // monitor: the DUT presents a registered output every cycle
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            n_cmp++;
            if (bus.out !== x.out || bus.idx !== x.idx ||
                bus.wrap !== x.wrap || bus.busy !== x.busy) begin
               n_bad++;
               $display("FAIL %s: got out=%h idx=%0d wrap=%b busy=%b, expected out=%h idx=%0d wrap=%b busy=%b",
                        x.name, bus.out, bus.idx, bus.wrap, bus.busy,
                        x.out, x.idx, x.wrap, x.busy);
            end
         end
      end
   end

   initial begin
      logic [2:0] k3;
      bus.en = 1'b0; bus.mode = MODE_DIRECT; bus.in = '0;
      bus.load = 1'b0; bus.dwell = '0;

      cyc(1, 0, MODE_DIRECT, 0, 0, 0, 8'h00, 0, 0, 0, "reset");
      cyc(1, 1, MODE_SHOT,   3, 1, 0, 8'h00, 0, 0, 0, "reset_busy_inputs");

`ifdef DEC_SCANNER_BLANK_EN
      cyc(0, 1, MODE_UP, 0, 1, 0, 8'h01, 0, 0, 0, "blank_load");
      for (int k = 0; k < 8; k++) begin
         k3 = 3'(k + 1);
         cyc(0, 1, MODE_UP, 0, 0, 0, 8'h00, k3, (k == 7), 0, "blank_gap");
         cyc(0, 1, MODE_UP, 0, 0, 0, 8'h01 << k3, k3, 0, 0, "blank_chan");
      end
`else
      // direct select
      for (int k = 0; k < 8; k++)
         cyc(0, 1, MODE_DIRECT, 3'(k), 0, 0, 8'h01 << k, 3'(k), 0, 0, "direct");
      cyc(0, 0, MODE_DIRECT, 2, 0, 0, 8'h00, 7, 0, 0, "direct_en_low");

      // scan-up dwell=2: 3 cycles per channel, wrap back to 0x01 after 24
      cyc(0, 1, MODE_UP, 0, 1, 2, 8'h01, 0, 0, 0, "up_load");
      for (int p = 1; p <= 26; p++) begin
         k3 = 3'((p / 3) % 8);
         cyc(0, 1, MODE_UP, 0, 0, 2, 8'h01 << k3, k3, (p == 24), 0, "scan_up");
      end

      // scan-down dwell=0 from 5
      cyc(0, 1, MODE_DOWN, 5, 1, 0, 8'h20, 5, 0, 0, "down_load");
      cyc(0, 1, MODE_DOWN, 0, 0, 0, 8'h10, 4, 0, 0, "scan_down");
      cyc(0, 1, MODE_DOWN, 0, 0, 0, 8'h08, 3, 0, 0, "scan_down");
      cyc(0, 1, MODE_DOWN, 0, 0, 0, 8'h04, 2, 0, 0, "scan_down");
      cyc(0, 1, MODE_DOWN, 0, 0, 0, 8'h02, 1, 0, 0, "scan_down");
      cyc(0, 1, MODE_DOWN, 0, 0, 0, 8'h01, 0, 0, 0, "scan_down");
      cyc(0, 1, MODE_DOWN, 0, 0, 0, 8'h80, 7, 1, 0, "down_wrap");
      cyc(0, 1, MODE_DOWN, 0, 0, 0, 8'h40, 6, 0, 0, "scan_down");

      // single-shot dwell=1
      cyc(0, 1, MODE_SHOT, 0, 0, 1, 8'h00, 6, 0, 0, "shot_enter_idle");
      cyc(0, 1, MODE_SHOT, 0, 1, 1, 8'h01, 0, 0, 1, "shot_load");
      for (int p = 1; p <= 15; p++) begin
         k3 = 3'(p / 2);
         cyc(0, 1, MODE_SHOT, 0, 0, 1, 8'h01 << k3, k3, 0, 1, "shot_run");
      end
      cyc(0, 1, MODE_SHOT, 0, 0, 1, 8'h00, 0, 1, 0, "shot_done");
      cyc(0, 1, MODE_SHOT, 0, 0, 1, 8'h00, 0, 0, 0, "shot_idle");
      cyc(0, 1, MODE_SHOT, 0, 1, 1, 8'h01, 0, 0, 1, "shot_load2");
      for (int p = 1; p <= 8; p++) begin
         k3 = 3'(p / 2);
         cyc(0, 1, MODE_SHOT, 0, 0, 1, 8'h01 << k3, k3, 0, 1, "shot_run2");
      end
      cyc(0, 1, MODE_SHOT, 0, 1, 1, 8'h01, 0, 0, 1, "shot_restart");
      for (int p = 1; p <= 12; p++) begin
         k3 = 3'(p / 2);
         cyc(0, 1, MODE_SHOT, 0, 0, 1, 8'h01 << k3, k3, 0, 1, "shot_run3");
      end
      cyc(1, 1, MODE_SHOT, 0, 1, 1, 8'h00, 0, 0, 0, "reset_mid_shot");
      cyc(0, 1, MODE_SHOT, 0, 0, 1, 8'h00, 0, 0, 0, "after_reset_idle");

      // en low mid-dwell at idx 3, then a mode change clearing cnt
      cyc(0, 1, MODE_UP, 2, 1, 3, 8'h04, 2, 0, 0, "hold_load");
      for (int p = 1; p <= 3; p++)
         cyc(0, 1, MODE_UP, 0, 0, 3, 8'h04, 2, 0, 0, "hold_pre");
      cyc(0, 1, MODE_UP, 0, 0, 3, 8'h08, 3, 0, 0, "hold_pre");
      cyc(0, 1, MODE_UP, 0, 0, 3, 8'h08, 3, 0, 0, "hold_pre");
      for (int p = 0; p < 5; p++)
         cyc(0, 0, MODE_UP, 0, 1, 3, 8'h00, 3, 0, 0, "en_low_hold");
      cyc(0, 1, MODE_UP, 0, 0, 3, 8'h08, 3, 0, 0, "resume");
      cyc(0, 1, MODE_UP, 0, 0, 3, 8'h08, 3, 0, 0, "resume");
      cyc(0, 1, MODE_UP, 0, 0, 3, 8'h10, 4, 0, 0, "resume_step");
      cyc(0, 1, MODE_UP, 0, 0, 3, 8'h10, 4, 0, 0, "resume_step");
      cyc(0, 1, MODE_DOWN, 0, 0, 3, 8'h10, 4, 0, 0, "mode_chg_hold");
      for (int p = 0; p < 3; p++)
         cyc(0, 1, MODE_DOWN, 0, 0, 3, 8'h10, 4, 0, 0, "mode_chg_cnt");
      cyc(0, 1, MODE_DOWN, 0, 0, 3, 8'h08, 3, 0, 0, "mode_chg_step");
`endif

      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dec_scanner.md
DEC_SCANNER -- requirements
Module: dec_scanner

Interface
REQ-001 Parameter SEL_W, default 3: select width; output width is 2**SEL_W (legal range 1..6).
REQ-002 Parameter DWELL_W, default 8: dwell counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  global enable; low blanks output and freezes state.
REQ-006 mode  input  2  00 direct, 01 scan-up, 10 scan-down, 11 single-shot.
REQ-007 in  input  SEL_W  direct-mode select, or load value in modes 01/10.
REQ-008 load  input  1  single-cycle strobe: preset index (01/10) or start sequence (11).
REQ-009 dwell  input  DWELL_W  extra hold cycles per channel; sampled live.
REQ-010 out  output  2**SEL_W  registered one-hot channel select, or all-zero.
REQ-011 idx  output  SEL_W  registered current channel index.
REQ-012 wrap  output  1  one-cycle pulse on sequence wrap or single-shot completion.
REQ-013 busy  output  1  high while a single-shot sequence runs.

Function
REQ-014 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-015 Mode 00, en=1: idx <= in, out <= 1<<in, 1-cycle latency; busy=0, wrap=0, counter held at 0.
REQ-016 Modes 01/10/11 running: out SHALL equal 1<<idx; dwell counter cnt increments each en=1 cycle; at cnt==dwell, cnt <= 0 and idx steps (+1 in 01/11, -1 in 10); each channel is held dwell+1 cycles; dwell=0 steps every cycle.
REQ-017 Index arithmetic SHALL be modulo 2**SEL_W; wrap pulses in the same cycle the wrapped idx (0 for up, max for down) first appears.
REQ-018 load in 01/10: idx <= in, cnt <= 0, out <= 1<<in next cycle; load wins over a coincident step.
REQ-019 Mode 11: FSM states IDLE, RUN; IDLE: out=0, busy=0; load -> RUN with idx=0, busy=1; RUN steps per REQ-016; when the dwell of channel max expires -> IDLE, out=0, idx=0, busy=0, wrap=1 for one cycle.
REQ-020 load during RUN SHALL restart at idx=0 with cnt=0; load in mode 00 is ignored.
REQ-021 en=0: out <= 0, wrap <= 0; idx, cnt, FSM state and busy hold; load ignored; resume on en=1 continues from the held idx and cnt.
REQ-022 Any mode change SHALL clear cnt and hold idx; entering 11 without load goes to IDLE.

Reset
REQ-023 rst=1 SHALL force out=0, idx=0, wrap=0, busy=0, cnt=0, FSM=IDLE on the next edge, regardless of en, load or mode, including mid-sequence.

Configuration
REQ-024 Macro DEC_SCANNER_BLANK_EN defined: every index step SHALL insert exactly one cycle of out=0 (idx already updated, wrap asserted in that cycle); blank cycle not counted in dwell; per-channel period is dwell+2.
REQ-025 Macro undefined: no blank cycle; out switches directly between one-hot codes.

Structure
REQ-026 Package dec_scanner_pkg SHALL hold mode encodings (MODE_DIRECT, MODE_UP, MODE_DOWN, MODE_SHOT) and the FSM state typedef.
REQ-027 Sub-module dec_onehot (combinational SEL_W-to-2**SEL_W decoder with enable) SHALL generate the one-hot code feeding the out register.

Verification (SEL_W=3, macro undefined unless noted)
REQ-028 Direct: en=1, mode=00, in=0..7 -> out 0x01..0x80 one cycle later; en=0 -> out=0x00 next cycle.
REQ-029 Scan-up dwell=2: each of 0x01..0x80 held 3 cycles, then 0x01 with wrap=1 for one cycle; period 24 cycles.
REQ-030 Scan-down dwell=0, load in=5: out 0x20,0x10,0x08,0x04,0x02,0x01,0x80 (wrap=1 at 0x80).
REQ-031 Single-shot dwell=1, load: 0x01..0x80 two cycles each, then out=0, busy falls, one wrap pulse; second load at idx=4 restarts at 0x01.
REQ-032 rst at idx=6 mid-scan -> next cycle out=0, idx=0, busy=0; en low 5 cycles at idx=3 -> idx holds 3, out=0, resume at 0x08 with remaining dwell.
REQ-033 DEC_SCANNER_BLANK_EN, scan-up dwell=0: out 0x01,0x00,0x02,0x00,...,0x80,0x00(wrap=1),0x01.
